// File: rtl/ram_fill_verify.sv
// Fill+verify sequencer for the 64x32 data RAM: writes a pattern over an address
// range, reads it back with a two-edge compare pipeline, and reports the first mismatch.
module ram_fill_verify #(
    parameter logic [5:0] START_ADDR = 6'd0,
    parameter logic [5:0] END_ADDR   = 6'd63
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Pattern_Sel,
    input  logic [31:0] Base_Data,
    output logic [5:0]  Mem_Addr,
    output logic        Mem_Write,
    output logic [31:0] M_W_Data,
    input  logic [31:0] M_R_Data,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [5:0]  Err_Addr,
    output logic [31:0] Err_Data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  sel_q;
    logic [31:0] base_q;
    logic [5:0]  addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        rd_pend_q;
    logic        cmp_vld_q;
    logic [5:0]  cmp_addr_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic [5:0]  err_addr_q;
    logic [31:0] err_data_q;

    // Pattern generator; also used to regenerate expected read data.
    function automatic logic [31:0] pattern(input logic [1:0] sel, input logic [31:0] b,
                                            input logic [5:0] a);
        logic [5:0]  rsh;
        logic [31:0] r;
        rsh = 6'd32 - {1'b0, a[4:0]};
        case (sel)
            2'd0:    r = b;
            2'd1:    r = b + {26'b0, a};
            2'd2:    r = {4{2'b00, a}};
            default: r = (b << a[4:0]) | (b >> rsh);
        endcase
        return r;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            sel_q      <= 2'd0;
            base_q     <= 32'd0;
            addr_q     <= 6'd0;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
            rd_pend_q  <= 1'b0;
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= 6'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= 6'd0;
            err_data_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        state_q    <= S_WRITE;
                        sel_q      <= Pattern_Sel;
                        base_q     <= Base_Data;
                        addr_q     <= START_ADDR;
                        we_q       <= 1'b1;
                        wdata_q    <= pattern(Pattern_Sel, Base_Data, START_ADDR);
                        rd_pend_q  <= 1'b0;
                        cmp_vld_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        err_addr_q <= 6'd0;
                        err_data_q <= 32'd0;
                    end
                end
                S_WRITE: begin
                    if (addr_q == END_ADDR) begin
                        state_q   <= S_READ;
                        we_q      <= 1'b0;
                        addr_q    <= START_ADDR;
                        rd_pend_q <= 1'b1;
                    end else begin
                        addr_q  <= addr_q + 6'd1;
                        wdata_q <= pattern(sel_q, base_q, addr_q + 6'd1);
                    end
                end
                S_READ: begin
                    // Address issued this cycle is compared two edges later.
                    cmp_vld_q  <= rd_pend_q;
                    cmp_addr_q <= addr_q;
                    if (rd_pend_q) begin
                        if (addr_q == END_ADDR) begin
                            rd_pend_q <= 1'b0;
                        end else begin
                            addr_q <= addr_q + 6'd1;
                        end
                    end
                    if (cmp_vld_q) begin
                        if (M_R_Data != pattern(sel_q, base_q, cmp_addr_q)) begin
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            error_q    <= 1'b1;
                            err_addr_q <= cmp_addr_q;
                            err_data_q <= M_R_Data;
                            rd_pend_q  <= 1'b0;
                            cmp_vld_q  <= 1'b0;
                        end else if (cmp_addr_q == END_ADDR) begin
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            rd_pend_q <= 1'b0;
                            cmp_vld_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Mem_Addr  = addr_q;
    assign Mem_Write = we_q;
    assign M_W_Data  = wdata_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Error     = error_q;
    assign Err_Addr  = err_addr_q;
    assign Err_Data  = err_data_q;

endmodule
